// File: rtl/gpu_receiver_stream_if.sv
// Rect word stream in, GPU memory bank writes out.
// Master drives the stream and sinks the writes.
interface gpu_receiver_stream_if #(
  parameter int RECT_COUNT_WIDTH = 6
);
  logic                        in_valid;
  logic [15:0]                 in_data;
  logic                        in_ready;
  logic                        we;
  logic [2:0]                  mem_select;
  logic [RECT_COUNT_WIDTH-1:0] dout_addr;
  logic [15:0]                 dout;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  we,
    input  mem_select,
    input  dout_addr,
    input  dout
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output we,
    output mem_select,
    output dout_addr,
    output dout
  );
endinterface

// File: rtl/gpu_receiver_stream.sv
// Streams x/y/w/h/color words per rect, clamps to the screen and
// writes left/top/right/bottom/color/non-empty into six GPU banks.
module gpu_receiver_stream #(
  parameter int COORD_WIDTH      = 10,
  parameter int RECT_COUNT       = 64,
  parameter int RECT_COUNT_WIDTH = 6,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  gpu_receiver_stream_if.slave bus,
  output logic busy,
  output logic finish
);

  typedef enum logic [2:0] {
    IDLE, RX_X, RX_Y, RX_W, RX_H, RX_C, FLAG
  } state_t;

  localparam logic signed [16:0] LIM_W = 17'(SCREEN_W);
  localparam logic signed [16:0] LIM_H = 17'(SCREEN_H);
  localparam logic [RECT_COUNT_WIDTH-1:0] LAST =
    RECT_COUNT_WIDTH'(RECT_COUNT - 1);

  state_t                      state_q, state_d;
  logic [RECT_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]                 raw_x_q, raw_x_d;
  logic [15:0]                 raw_y_q, raw_y_d;
  logic [COORD_WIDTH-1:0]      x1_q, x1_d;
  logic [COORD_WIDTH-1:0]      y1_q, y1_d;
  logic [COORD_WIDTH-1:0]      x2_q, x2_d;
  logic [COORD_WIDTH-1:0]      y2_q, y2_d;

  logic signed [16:0] in_s;
  logic signed [16:0] sum_x;
  logic signed [16:0] sum_y;
  logic [15:0]        cv;
  logic               nonempty;

  // 17-bit sums so x+w never wraps before clamping
  assign in_s  = $signed({bus.in_data[15], bus.in_data});
  assign sum_x = $signed({raw_x_q[15], raw_x_q}) + in_s;
  assign sum_y = $signed({raw_y_q[15], raw_y_q}) + in_s;

  assign nonempty = (x2_q > x1_q) && (y2_q > y1_q);

  function automatic logic [15:0] clamp(
    input logic signed [16:0] v,
    input logic signed [16:0] lim
  );
    if (v < 17'sd0) return 16'd0;
    if (v >= lim)   return lim[15:0];
    return v[15:0];
  endfunction

  assign busy          = (state_q != IDLE);
  assign finish        = (state_q == FLAG) && (cnt_q == LAST);
  assign bus.dout_addr = cnt_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    raw_x_d        = raw_x_q;
    raw_y_d        = raw_y_q;
    x1_d           = x1_q;
    y1_d           = y1_q;
    x2_d           = x2_q;
    y2_d           = y2_q;
    cv             = 16'd0;
    bus.in_ready   = 1'b0;
    bus.we         = 1'b0;
    bus.mem_select = 3'd0;
    bus.dout       = 16'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RX_X;
          cnt_d   = '0;
        end
      end
      RX_X: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          cv      = clamp(in_s, LIM_W);
          bus.we  = 1'b1;
          bus.dout = cv;
          raw_x_d = bus.in_data;
          x1_d    = cv[COORD_WIDTH-1:0];
          state_d = RX_Y;
        end
      end
      RX_Y: begin
        bus.in_ready   = 1'b1;
        bus.mem_select = 3'd1;
        if (bus.in_valid) begin
          cv      = clamp(in_s, LIM_H);
          bus.we  = 1'b1;
          bus.dout = cv;
          raw_y_d = bus.in_data;
          y1_d    = cv[COORD_WIDTH-1:0];
          state_d = RX_W;
        end
      end
      RX_W: begin
        bus.in_ready   = 1'b1;
        bus.mem_select = 3'd2;
        if (bus.in_valid) begin
          cv      = clamp(sum_x, LIM_W);
          bus.we  = 1'b1;
          bus.dout = cv;
          x2_d    = cv[COORD_WIDTH-1:0];
          state_d = RX_H;
        end
      end
      RX_H: begin
        bus.in_ready   = 1'b1;
        bus.mem_select = 3'd3;
        if (bus.in_valid) begin
          cv      = clamp(sum_y, LIM_H);
          bus.we  = 1'b1;
          bus.dout = cv;
          y2_d    = cv[COORD_WIDTH-1:0];
          state_d = RX_C;
        end
      end
      RX_C: begin
        bus.in_ready   = 1'b1;
        bus.mem_select = 3'd4;
        if (bus.in_valid) begin
          bus.we   = 1'b1;
          bus.dout = bus.in_data;
          state_d  = FLAG;
        end
      end
      FLAG: begin
        bus.we         = 1'b1;
        bus.mem_select = 3'd5;
        bus.dout       = {15'd0, nonempty};
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RX_X;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      raw_x_q <= '0;
      raw_y_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_x_q <= raw_x_d;
      raw_y_q <= raw_y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
    end
  end

endmodule

// File: tb/tb_gpu_receiver_stream.sv
// Randomized bench for gpu_receiver_stream against a rect-level
// reference model; a 64-rect and a 1-rect instance share stimulus.
module tb_gpu_receiver_stream;

  localparam int SW = 640;
  localparam int SH = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        busy64, finish64, busy1, finish1;

  gpu_receiver_stream_if #(.RECT_COUNT_WIDTH(6)) if64 ();
  gpu_receiver_stream_if #(.RECT_COUNT_WIDTH(1)) if1 ();

  assign if64.in_valid = in_valid;
  assign if64.in_data  = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;

  gpu_receiver_stream #(
    .COORD_WIDTH(10), .RECT_COUNT(64), .RECT_COUNT_WIDTH(6),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .bus(if64.slave),
    .busy(busy64), .finish(finish64)
  );

  gpu_receiver_stream #(
    .COORD_WIDTH(10), .RECT_COUNT(1), .RECT_COUNT_WIDTH(1),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .bus(if1.slave),
    .busy(busy1), .finish(finish1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int sel;
    int data;
  } wr_t;

  wr_t wq64[$];
  wr_t wq1[$];
  wr_t exp_q[$];
  wr_t ref_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fin64_cnt = 0;
  int fin64_at = 0;
  int fin1_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if64.we === 1'b1)
      wq64.push_back('{int'(if64.dout_addr),
                       int'(if64.mem_select), int'(if64.dout)});
    if (if1.we === 1'b1)
      wq1.push_back('{int'(if1.dout_addr),
                      int'(if1.mem_select), int'(if1.dout)});
    if (finish64 === 1'b1) begin
      fin64_cnt++;
      fin64_at = cyc - start_cyc + 1;
    end
    if (finish1 === 1'b1) fin1_cnt++;
  end

  function automatic int clampi(int v, int l);
    if (v < 0) return 0;
    if (v >= l) return l;
    return v;
  endfunction

  // Expected six bank writes of one rect, straight from the clamp rules
  task automatic model_rect(input int a, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] w,
                            input logic [15:0] h, input logic [15:0] c);
    int xi, yi, wi, hi, l, t, r, b;
    xi = int'($signed(x));
    yi = int'($signed(y));
    wi = int'($signed(w));
    hi = int'($signed(h));
    l = clampi(xi, SW);
    t = clampi(yi, SH);
    r = clampi(xi + wi, SW);
    b = clampi(yi + hi, SH);
    exp_q.push_back('{a, 0, l});
    exp_q.push_back('{a, 1, t});
    exp_q.push_back('{a, 2, r});
    exp_q.push_back('{a, 3, b});
    exp_q.push_back('{a, 4, int'(c)});
    exp_q.push_back('{a, 5, (r > l && b > t) ? 1 : 0});
  endtask

  function automatic logic [15:0] rnd_word();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 831)) - 16'd64;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq64.delete();
    wq1.delete();
    exp_q.delete();
    fin64_cnt = 0;
    fin1_cnt = 0;
    fin64_at = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic drive_word(input logic [15:0] v, input int gaps,
                            output int gbad, output int tmo);
    gbad = 0;
    tmo = 0;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
      if (if64.in_ready !== 1'b1 || if64.we !== 1'b0) gbad++;
      step();
    end
    in_valid = 1'b1;
    in_data = v;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if64.in_ready === 1'b1) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    tmo = 1;
  endtask

  // Gap checks skip the x word: its first gap overlaps the FLAG cycle
  task automatic send_rect(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] c, input int gaps,
                           inout int gbad, inout int tmo);
    int gb, tm;
    drive_word(x, gaps, gb, tm); tmo += tm;
    drive_word(y, gaps, gb, tm); tmo += tm; gbad += gb;
    drive_word(w, gaps, gb, tm); tmo += tm; gbad += gb;
    drive_word(h, gaps, gb, tm); tmo += tm; gbad += gb;
    drive_word(c, gaps, gb, tm); tmo += tm; gbad += gb;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (if64.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b exp 0", if64.in_ready);
    end
    n_checks++;
    if (if64.we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_we got %b exp 0", if64.we);
    end
    n_checks++;
    if (busy64 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b/%b exp 0", busy64, busy1);
    end
    n_checks++;
    if (finish64 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_finish got %b exp 0", finish64);
    end
    n_checks++;
    if (if64.dout_addr !== 6'd0 || if64.mem_select !== 3'd0 ||
        if64.dout !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_bus got addr %0d sel %0d dout %h exp 0",
               if64.dout_addr, if64.mem_select, if64.dout);
    end
    step();
  endtask

  task automatic test_single();
    int gb = 0, tm = 0;
    do_reset();
    pulse_start();
    send_rect(16'd10, 16'd20, 16'd30, 16'd40, 16'h1234, 0, gb, tm);
    model_rect(0, 16'd10, 16'd20, 16'd30, 16'd40, 16'h1234);
    @(negedge clk);
    n_checks++;
    if (finish1 !== 1'b1 || if1.mem_select !== 3'd5) begin
      n_fail++;
      $display("FAIL single_finish got %b sel %0d exp 1 sel 5",
               finish1, if1.mem_select);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop got %b exp 0", busy1);
    end
    step();
    n_checks++;
    if (tm != 0 || wq1.size() != 6 || fin1_cnt != 1) begin
      n_fail++;
      $display("FAIL single_count got %0d writes %0d fin tmo %0d exp 6 1 0",
               wq1.size(), fin1_cnt, tm);
    end
    for (int i = 0; i < 6 && i < wq1.size(); i++) begin
      n_checks++;
      if (wq1[i].addr != exp_q[i].addr || wq1[i].sel != exp_q[i].sel ||
          wq1[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL single_wr%0d got a%0d s%0d d%0h exp a%0d s%0d d%0h",
                 i, wq1[i].addr, wq1[i].sel, wq1[i].data,
                 exp_q[i].addr, exp_q[i].sel, exp_q[i].data);
      end
    end
    n_checks++;
    if (wq1.size() == 6 && wq1[2].data != 40) begin
      n_fail++;
      $display("FAIL single_right got %0d exp 40", wq1[2].data);
    end
  endtask

  task automatic test_clamp();
    int gb = 0, tm = 0;
    logic [15:0] c;
    c = 16'($urandom);
    do_reset();
    pulse_start();
    send_rect(16'hFFFB, 16'd700, 16'h7FFF, 16'hFFFD, c, 0, gb, tm);
    model_rect(0, 16'hFFFB, 16'd700, 16'h7FFF, 16'hFFFD, c);
    step();
    step();
    n_checks++;
    if (tm != 0 || wq64.size() != 6) begin
      n_fail++;
      $display("FAIL clamp_count got %0d writes tmo %0d exp 6 0",
               wq64.size(), tm);
    end
    for (int i = 0; i < 6 && i < wq64.size(); i++) begin
      n_checks++;
      if (wq64[i].addr != exp_q[i].addr || wq64[i].sel != exp_q[i].sel ||
          wq64[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL clamp_wr%0d got a%0d s%0d d%0d exp a%0d s%0d d%0d",
                 i, wq64[i].addr, wq64[i].sel, wq64[i].data,
                 exp_q[i].addr, exp_q[i].sel, exp_q[i].data);
      end
    end
    n_checks++;
    if (wq64.size() == 6 && (wq64[2].data != 640 || wq64[5].data != 0)) begin
      n_fail++;
      $display("FAIL clamp_edge got right %0d flag %0d exp 640 0",
               wq64[2].data, wq64[5].data);
    end
  endtask

  task automatic test_stalls();
    logic [15:0] rr [3][5];
    int gb = 0, tm = 0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 5; k++) rr[r][k] = rnd_word();
    do_reset();
    pulse_start();
    for (int r = 0; r < 3; r++)
      send_rect(rr[r][0], rr[r][1], rr[r][2], rr[r][3], rr[r][4],
                0, gb, tm);
    step();
    step();
    ref_q = wq64;
    do_reset();
    pulse_start();
    gb = 0;
    for (int r = 0; r < 3; r++) begin
      send_rect(rr[r][0], rr[r][1], rr[r][2], rr[r][3], rr[r][4],
                3, gb, tm);
      model_rect(r, rr[r][0], rr[r][1], rr[r][2], rr[r][3], rr[r][4]);
    end
    step();
    step();
    n_checks++;
    if (gb != 0 || tm != 0) begin
      n_fail++;
      $display("FAIL stall_gaps got %0d bad gaps %0d tmo exp 0 0", gb, tm);
    end
    n_checks++;
    if (wq64.size() != 18 || ref_q.size() != 18) begin
      n_fail++;
      $display("FAIL stall_count got %0d/%0d writes exp 18",
               wq64.size(), ref_q.size());
    end
    for (int i = 0; i < 18 && i < wq64.size() && i < ref_q.size(); i++) begin
      n_checks++;
      if (wq64[i].addr != exp_q[i].addr || wq64[i].sel != exp_q[i].sel ||
          wq64[i].data != exp_q[i].data || ref_q[i].data != exp_q[i].data ||
          ref_q[i].addr != exp_q[i].addr) begin
        n_fail++;
        $display("FAIL stall_wr%0d got a%0d s%0d d%0h nostall d%0h exp a%0d s%0d d%0h",
                 i, wq64[i].addr, wq64[i].sel, wq64[i].data, ref_q[i].data,
                 exp_q[i].addr, exp_q[i].sel, exp_q[i].data);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] v [5];
    int gb = 0, tm = 0, bad = 0, waited = 0;
    do_reset();
    pulse_start();
    for (int r = 0; r < 64; r++) begin
      for (int k = 0; k < 5; k++) v[k] = rnd_word();
      send_rect(v[0], v[1], v[2], v[3], v[4], 0, gb, tm);
      model_rect(r, v[0], v[1], v[2], v[3], v[4]);
    end
    while (busy64 === 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (busy64 !== 1'b0 || tm != 0) begin
      n_fail++;
      $display("FAIL frame_done got busy %b tmo %0d exp 0 0", busy64, tm);
    end
    n_checks++;
    if (wq64.size() != 384) begin
      n_fail++;
      $display("FAIL frame_writes got %0d exp 384", wq64.size());
    end
    for (int i = 0; i < 384 && i < wq64.size(); i++)
      if (wq64[i].addr != exp_q[i].addr || wq64[i].sel != exp_q[i].sel ||
          wq64[i].data != exp_q[i].data) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL frame_data got %0d wrong writes exp 0", bad);
    end
    n_checks++;
    if (fin64_cnt != 1 || fin64_at != 384) begin
      n_fail++;
      $display("FAIL frame_finish got %0d pulses at %0d exp 1 at 384",
               fin64_cnt, fin64_at);
    end
    clear_logs();
    pulse_start();
    for (int k = 0; k < 5; k++) v[k] = rnd_word();
    send_rect(v[0], v[1], v[2], v[3], v[4], 0, gb, tm);
    model_rect(0, v[0], v[1], v[2], v[3], v[4]);
    step();
    step();
    n_checks++;
    if (wq64.size() != 6 || wq64[0].addr != 0 || wq64[5].addr != 0 ||
        wq64[5].data != exp_q[5].data) begin
      n_fail++;
      $display("FAIL frame_restart got %0d writes exp 6 at addr 0",
               wq64.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v [5];
    int gb = 0, tm = 0;
    do_reset();
    pulse_start();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) v[k] = rnd_word();
      send_rect(v[0], v[1], v[2], v[3], v[4], 0, gb, tm);
    end
    drive_word(rnd_word(), 0, gb, tm);
    drive_word(rnd_word(), 0, gb, tm);
    n_checks++;
    if (if64.dout_addr !== 6'd5 || if64.mem_select !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_position got addr %0d sel %0d exp 5 2",
               if64.dout_addr, if64.mem_select);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy64 !== 1'b0 || if64.we !== 1'b0 || if64.dout_addr !== 6'd0 ||
        if64.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got busy %b we %b addr %0d rdy %b exp 0",
               busy64, if64.we, if64.dout_addr, if64.in_ready);
    end
    step();
    clear_logs();
    pulse_start();
    for (int k = 0; k < 5; k++) v[k] = rnd_word();
    send_rect(v[0], v[1], v[2], v[3], v[4], 0, gb, tm);
    model_rect(0, v[0], v[1], v[2], v[3], v[4]);
    step();
    step();
    n_checks++;
    if (wq64.size() != 6) begin
      n_fail++;
      $display("FAIL mid_restart_count got %0d exp 6", wq64.size());
    end
    for (int i = 0; i < 6 && i < wq64.size(); i++) begin
      n_checks++;
      if (wq64[i].addr != exp_q[i].addr || wq64[i].sel != exp_q[i].sel ||
          wq64[i].data != exp_q[i].data) begin
        n_fail++;
        $display("FAIL mid_wr%0d got a%0d s%0d d%0h exp a%0d s%0d d%0h",
                 i, wq64[i].addr, wq64[i].sel, wq64[i].data,
                 exp_q[i].addr, exp_q[i].sel, exp_q[i].data);
      end
    end
  endtask

  task automatic test_ignored();
    logic [15:0] v [5];
    int gb = 0, tm = 0, bad = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 16'($urandom);
      @(negedge clk);
      if (if64.we !== 1'b0 || busy64 !== 1'b0) bad++;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0 || wq64.size() != 0) begin
      n_fail++;
      $display("FAIL idle_valid got %0d bad cycles %0d writes exp 0 0",
               bad, wq64.size());
    end
    for (int k = 0; k < 5; k++) v[k] = rnd_word();
    pulse_start();
    drive_word(v[0], 0, gb, tm);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      @(negedge clk);
      if (busy64 !== 1'b1 || if64.we !== 1'b0 ||
          if64.in_ready !== 1'b1 || if64.mem_select !== 3'd1) bad++;
      step();
    end
    start = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_start got %0d bad cycles exp 0", bad);
    end
    drive_word(v[1], 0, gb, tm);
    drive_word(v[2], 0, gb, tm);
    drive_word(v[3], 0, gb, tm);
    drive_word(v[4], 0, gb, tm);
    model_rect(0, v[0], v[1], v[2], v[3], v[4]);
    step();
    step();
    bad = 0;
    for (int i = 0; i < 6 && i < wq64.size(); i++)
      if (wq64[i].addr != exp_q[i].addr || wq64[i].sel != exp_q[i].sel ||
          wq64[i].data != exp_q[i].data) bad++;
    n_checks++;
    if (wq64.size() != 6 || bad != 0) begin
      n_fail++;
      $display("FAIL busy_start_data got %0d writes %0d wrong exp 6 0",
               wq64.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clamp();
    test_stalls();
    test_full_frame();
    test_reset_mid();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
